mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: MEM_WB  in  2  WB control; bit1=RegWrite, bit0=MemToReg.
REQ-004 SHALL have: MEM_M  in  3  MEM control; bit2=Branch, bit1=MemRead, bit0=MemWrite.
REQ-005 SHALL have: MEM_SumRes  in  32  branch target; MEM_ZFlag  in  1  ALU zero.
REQ-006 SHALL have: MEM_ALURes  in  32  byte address or ALU result; MEM_DatoLeidoB  in  32  store data.
REQ-007 SHALL have: MEM_MUXRes  in  5  destination register; MEM_Flush  in  1  squash current instruction.
REQ-008 SHALL have: MEM_PCSrc  out  1  branch taken; MEM_BranchTarget  out  32  next PC on taken branch.
REQ-009 SHALL have: MEMWB_WBout  out  2; MEMWB_DatoLeidoout  out  32; MEMWB_ALUResout  out  32; MEMWB_MUXResout  out  5.
REQ-010 SHALL have: MEM_AlignErr  out  1  sticky misalignment flag.

Function
REQ-011 MEM_PCSrc SHALL be combinational: MEM_M[2] AND MEM_ZFlag AND NOT MEM_Flush.
REQ-012 MEM_BranchTarget SHALL be combinational pass-through of MEM_SumRes.
REQ-013 Data memory SHALL be 128 x 32-bit words, indexed by MEM_ALURes[8:2]; bits 31:9 ignored (address wraps modulo 512 bytes).
REQ-014 Write SHALL occur at rising clk when MEM_M[0]=1, MEM_Flush=0, rst_n=1; full 32-bit word, no byte enables.
REQ-015 Read SHALL be synchronous: when MEM_M[1]=1, addressed word loads into MEMWB_DatoLeidoout at the same edge; when MEM_M[1]=0, loads 0.
REQ-016 Same-edge read and write to same word SHALL return the old contents (read-first).
REQ-017 MEM_M[1]=1 and MEM_M[0]=1 together SHALL perform both, read-first.
REQ-018 Each edge SHALL register MEMWB_WBout<=MEM_WB, MEMWB_ALUResout<=MEM_ALURes, MEMWB_MUXResout<=MEM_MUXRes; latency exactly 1 cycle, no stall.
REQ-019 When MEM_Flush=1 the edge SHALL load all MEMWB_* outputs with 0 and suppress the memory write.

Reset
REQ-020 rst_n low SHALL immediately clear MEMWB_WBout, MEMWB_DatoLeidoout, MEMWB_ALUResout, MEMWB_MUXResout and MEM_AlignErr to 0, independent of clk.
REQ-021 Memory contents SHALL NOT be altered by reset; writes SHALL be blocked while rst_n low; first post-reset edge behaves normally.

Configuration
REQ-022 Macro MEM_ALIGN_CHK_EN defined: access (MemRead or MemWrite) with MEM_ALURes[1:0]!=0 SHALL suppress the write, load MEMWB_WBout with 0 and set MEM_AlignErr, which holds until reset.
REQ-023 Macro MEM_ALIGN_CHK_EN undefined: MEM_ALURes[1:0] SHALL be ignored and MEM_AlignErr tied to 0; port list identical.

Structure
REQ-024 Shared package mips_pkg SHALL hold M/WB bit-position constants, DMEM_DEPTH=128, DMEM_AW=7.
REQ-025 Memory array SHALL be a sub-module data_mem (sync read-first, single write port); pipeline register and control logic stay in mem_wb_stage.

Verification
REQ-026 Store 0xDEADBEEF at 0x10, then load 0x10 -> MEMWB_DatoLeidoout=0xDEADBEEF one cycle after load edge.
REQ-027 Same-edge load+store to 0x20 (old 0x11111111, new 0x22222222) -> read returns 0x11111111; next load returns 0x22222222.
REQ-028 Branch=1, ZFlag=1, SumRes=0x00400040 -> MEM_PCSrc=1, MEM_BranchTarget=0x00400040; ZFlag=0 -> MEM_PCSrc=0; Flush=1 -> MEM_PCSrc=0.
REQ-029 Store 0x12345678 to 0x200 -> word at 0x000 reads 0x12345678 (wrap); Flush=1 store to 0x04 -> contents unchanged, MEMWB_WBout=0.
REQ-030 MEM_ALIGN_CHK_EN defined, store to 0x13 -> no write, MEM_AlignErr=1 and stays 1 until rst_n pulse; undefined -> word 0x10 written.
REQ-031 Assert rst_n low mid-stream between edges -> all MEMWB_* and MEM_AlignErr read 0 immediately; memory data retained.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: control-bundle bit positions and data memory geometry.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam int WB_W        = 2;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam int M_W          = 3;
  localparam int M_BRANCH     = 2;
  localparam int M_MEMREAD    = 1;
  localparam int M_MEMWRITE   = 0;

  localparam int DMEM_DEPTH = 128;
  localparam int DMEM_AW    = 7;

endpackage

// File: rtl/mem_wb_stage_data_mem.sv
// Word-addressed data memory with a single write port and a synchronous, read-first read port.
module data_mem
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [DMEM_AW-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DMEM_DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  always_comb begin
    rdata_d = '0;
    if (re) rdata_d = mem_q[addr];
  end

  // The array has no reset so stored data survives a pipeline reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline register: branch resolution, data memory access and squash handling.
// Define MEM_ALIGN_CHK_EN to trap misaligned loads/stores into the sticky MEM_AlignErr flag.
module mem_wb_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WB_W-1:0]   MEM_WB,
  input  logic [M_W-1:0]    MEM_M,
  input  logic [DATA_W-1:0] MEM_SumRes,
  input  logic              MEM_ZFlag,
  input  logic [DATA_W-1:0] MEM_ALURes,
  input  logic [DATA_W-1:0] MEM_DatoLeidoB,
  input  logic [REG_AW-1:0] MEM_MUXRes,
  input  logic              MEM_Flush,
  output logic              MEM_PCSrc,
  output logic [DATA_W-1:0] MEM_BranchTarget,
  output logic [WB_W-1:0]   MEMWB_WBout,
  output logic [DATA_W-1:0] MEMWB_DatoLeidoout,
  output logic [DATA_W-1:0] MEMWB_ALUResout,
  output logic [REG_AW-1:0] MEMWB_MUXResout,
  output logic              MEM_AlignErr
);

  logic [WB_W-1:0]    wb_d, wb_q;
  logic [DATA_W-1:0]  alu_d, alu_q;
  logic [REG_AW-1:0]  dst_d, dst_q;
  logic               mem_we, mem_re;
  logic [DMEM_AW-1:0] mem_addr;
  logic               misaligned;

  // Byte address bits above the array size are dropped, so accesses wrap every 512 bytes.
  assign mem_addr         = MEM_ALURes[DMEM_AW+1:2];
  assign MEM_PCSrc        = MEM_M[M_BRANCH] & MEM_ZFlag & ~MEM_Flush;
  assign MEM_BranchTarget = MEM_SumRes;

`ifdef MEM_ALIGN_CHK_EN
  logic align_err_d, align_err_q;

  assign misaligned  = (MEM_M[M_MEMREAD] | MEM_M[M_MEMWRITE]) & (MEM_ALURes[1:0] != 2'b00) & ~MEM_Flush;
  assign align_err_d = align_err_q | misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) align_err_q <= 1'b0;
    else        align_err_q <= align_err_d;
  end

  assign MEM_AlignErr = align_err_q;
`else
  assign misaligned   = 1'b0;
  assign MEM_AlignErr = 1'b0;
`endif

  always_comb begin
    mem_re = MEM_M[M_MEMREAD] & ~MEM_Flush;
    mem_we = MEM_M[M_MEMWRITE] & ~MEM_Flush & ~misaligned & rst_n;
    wb_d   = misaligned ? '0 : MEM_WB;
    alu_d  = MEM_ALURes;
    dst_d  = MEM_MUXRes;
    // A squashed instruction must reach writeback as a bubble.
    if (MEM_Flush) begin
      wb_d  = '0;
      alu_d = '0;
      dst_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q  <= '0;
      alu_q <= '0;
      dst_q <= '0;
    end else begin
      wb_q  <= wb_d;
      alu_q <= alu_d;
      dst_q <= dst_d;
    end
  end

  data_mem u_data_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (MEM_DatoLeidoB),
    .rdata (MEMWB_DatoLeidoout)
  );

  assign MEMWB_WBout     = wb_q;
  assign MEMWB_ALUResout = alu_q;
  assign MEMWB_MUXResout = dst_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized self-checking bench for mem_wb_stage against a behavioural memory/pipeline model.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic [1:0]  MEM_WB;
  logic [2:0]  MEM_M;
  logic [31:0] MEM_SumRes;
  logic        MEM_ZFlag;
  logic [31:0] MEM_ALURes;
  logic [31:0] MEM_DatoLeidoB;
  logic [4:0]  MEM_MUXRes;
  logic        MEM_Flush;
  logic        MEM_PCSrc;
  logic [31:0] MEM_BranchTarget;
  logic [1:0]  MEMWB_WBout;
  logic [31:0] MEMWB_DatoLeidoout;
  logic [31:0] MEMWB_ALUResout;
  logic [4:0]  MEMWB_MUXResout;
  logic        MEM_AlignErr;

  int checks = 0;
  int errors = 0;

  logic [31:0] memModel [128];
  logic [1:0]  expWb;
  logic [31:0] expDat;
  logic [31:0] expAlu;
  logic [4:0]  expDst;
  logic        expErr;

  mem_wb_stage dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .MEM_WB             (MEM_WB),
    .MEM_M              (MEM_M),
    .MEM_SumRes         (MEM_SumRes),
    .MEM_ZFlag          (MEM_ZFlag),
    .MEM_ALURes         (MEM_ALURes),
    .MEM_DatoLeidoB     (MEM_DatoLeidoB),
    .MEM_MUXRes         (MEM_MUXRes),
    .MEM_Flush          (MEM_Flush),
    .MEM_PCSrc          (MEM_PCSrc),
    .MEM_BranchTarget   (MEM_BranchTarget),
    .MEMWB_WBout        (MEMWB_WBout),
    .MEMWB_DatoLeidoout (MEMWB_DatoLeidoout),
    .MEMWB_ALUResout    (MEMWB_ALUResout),
    .MEMWB_MUXResout    (MEMWB_MUXResout),
    .MEM_AlignErr       (MEM_AlignErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, "_wb"},  {30'd0, MEMWB_WBout}, {30'd0, expWb});
    checkOutput({tag, "_dat"}, MEMWB_DatoLeidoout, expDat);
    checkOutput({tag, "_alu"}, MEMWB_ALUResout, expAlu);
    checkOutput({tag, "_dst"}, {27'd0, MEMWB_MUXResout}, {27'd0, expDst});
    checkOutput({tag, "_err"}, {31'd0, MEM_AlignErr}, {31'd0, expErr});
  endtask

  // Drive one instruction, check the combinational branch outputs, clock it and check the register.
  task automatic applyStimulus(input string tag, input logic [1:0] wb, input logic [2:0] m,
                               input logic [31:0] sum, input logic z, input logic [31:0] alu,
                               input logic [31:0] wdata, input logic [4:0] dst, input logic flush);
    int  word;
    bit  isLoad, isStore, isBranch, trap;
    MEM_WB = wb; MEM_M = m; MEM_SumRes = sum; MEM_ZFlag = z;
    MEM_ALURes = alu; MEM_DatoLeidoB = wdata; MEM_MUXRes = dst; MEM_Flush = flush;
    isBranch = m[2]; isLoad = m[1]; isStore = m[0];
    #1;
    checkOutput({tag, "_pcsrc"}, {31'd0, MEM_PCSrc}, {31'd0, (isBranch && z && !flush)});
    checkOutput({tag, "_target"}, MEM_BranchTarget, sum);
    word = int'((alu % 32'd512) / 32'd4);
    trap = 1'b0;
`ifdef MEM_ALIGN_CHK_EN
    trap = (isLoad || isStore) && (alu % 32'd4 != 0) && !flush;
`endif
    expDat = (isLoad && !flush) ? memModel[word] : 32'd0;
    expWb  = (flush || trap) ? 2'd0 : wb;
    expAlu = flush ? 32'd0 : alu;
    expDst = flush ? 5'd0 : dst;
    if (trap) expErr = 1'b1;
    if (isStore && !flush && !trap) memModel[word] = wdata;
    @(posedge clk);
    #1;
    checkRegs(tag);
  endtask

  task automatic resetPulse(input string tag);
    rst_n = 1'b0;
    #1;
    expWb = 2'd0; expDat = 32'd0; expAlu = 32'd0; expDst = 5'd0; expErr = 1'b0;
    checkRegs({tag, "_async"});
    MEM_M = 3'b011; MEM_Flush = 1'b0; MEM_ALURes = 32'h10; MEM_DatoLeidoB = 32'hBAD0BAD0;
    MEM_WB = 2'b11; MEM_MUXRes = 5'd9;
    @(posedge clk);
    #1;
    checkRegs({tag, "_held"});
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] oldWord;
    rst_n = 1'b1;
    MEM_WB = '0; MEM_M = '0; MEM_SumRes = '0; MEM_ZFlag = 1'b0;
    MEM_ALURes = '0; MEM_DatoLeidoB = '0; MEM_MUXRes = '0; MEM_Flush = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    expWb = 2'd0; expDat = 32'd0; expAlu = 32'd0; expDst = 5'd0; expErr = 1'b0;
    checkRegs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 128; i++)
      applyStimulus("preload", 2'($urandom), 3'b001, $urandom, 1'b0, i * 4, $urandom, 5'($urandom), 1'b0);

    applyStimulus("st10", 2'b00, 3'b001, 32'h0, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0);
    applyStimulus("ld10", 2'b11, 3'b010, 32'h0, 1'b0, 32'h10, 32'h0, 5'd4, 1'b0);
    checkOutput("req26", MEMWB_DatoLeidoout, 32'hDEADBEEF);

    applyStimulus("st20", 2'b00, 3'b001, 32'h0, 1'b0, 32'h20, 32'h11111111, 5'd0, 1'b0);
    applyStimulus("ldst20", 2'b11, 3'b011, 32'h0, 1'b0, 32'h20, 32'h22222222, 5'd5, 1'b0);
    checkOutput("req27_old", MEMWB_DatoLeidoout, 32'h11111111);
    applyStimulus("ld20", 2'b11, 3'b010, 32'h0, 1'b0, 32'h20, 32'h0, 5'd5, 1'b0);
    checkOutput("req27_new", MEMWB_DatoLeidoout, 32'h22222222);

    applyStimulus("br_taken", 2'b00, 3'b100, 32'h00400040, 1'b1, 32'h0, 32'h0, 5'd0, 1'b0);
    applyStimulus("br_nz", 2'b00, 3'b100, 32'h00400040, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    applyStimulus("br_flush", 2'b10, 3'b100, 32'h00400040, 1'b1, 32'h4, 32'h0, 5'd3, 1'b1);

    applyStimulus("st200", 2'b00, 3'b001, 32'h0, 1'b0, 32'h200, 32'h12345678, 5'd0, 1'b0);
    applyStimulus("ld000", 2'b10, 3'b010, 32'h0, 1'b0, 32'h0, 32'h0, 5'd7, 1'b0);
    checkOutput("req29_wrap", MEMWB_DatoLeidoout, 32'h12345678);
    oldWord = memModel[1];
    applyStimulus("st04_flush", 2'b11, 3'b001, 32'h0, 1'b0, 32'h4, 32'hCAFEF00D, 5'd2, 1'b1);
    checkOutput("req29_flush_wb", {30'd0, MEMWB_WBout}, 32'd0);
    applyStimulus("ld04", 2'b10, 3'b010, 32'h0, 1'b0, 32'h4, 32'h0, 5'd2, 1'b0);
    checkOutput("req29_kept", MEMWB_DatoLeidoout, oldWord);

    oldWord = memModel[4];
    applyStimulus("st13", 2'b10, 3'b001, 32'h0, 1'b0, 32'h13, 32'hA5A5A5A5, 5'd1, 1'b0);
    applyStimulus("ld10b", 2'b10, 3'b010, 32'h0, 1'b0, 32'h10, 32'h0, 5'd1, 1'b0);
`ifdef MEM_ALIGN_CHK_EN
    checkOutput("req30_nowrite", MEMWB_DatoLeidoout, oldWord);
    checkOutput("req30_err", {31'd0, MEM_AlignErr}, 32'd1);
`else
    checkOutput("req30_write", MEMWB_DatoLeidoout, 32'hA5A5A5A5);
    checkOutput("req30_err", {31'd0, MEM_AlignErr}, 32'd0);
`endif
    applyStimulus("sticky", 2'b01, 3'b000, 32'h0, 1'b0, 32'h40, 32'h0, 5'd6, 1'b0);

    resetPulse("midreset");
    applyStimulus("ld10_post", 2'b11, 3'b010, 32'h0, 1'b0, 32'h10, 32'h0, 5'd8, 1'b0);
    applyStimulus("ld20_post", 2'b11, 3'b010, 32'h0, 1'b0, 32'h20, 32'h0, 5'd8, 1'b0);
    checkOutput("req31_retained", MEMWB_DatoLeidoout, 32'h22222222);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      applyStimulus("rand", 2'($urandom), 3'($urandom), $urandom, 1'($urandom), a, $urandom,
                    5'($urandom), ($urandom_range(7) == 0));
      if (i == 200) resetPulse("randreset");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
